// File: rtl/ring_rr_arbiter_if.sv
// Bundle between the requester blocks and ring_rr_arbiter.
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface ring_rr_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = 2,
  parameter int HC_W = 4
);
  logic [N-1:0]    req;
`ifdef RR_ARB_LOCK_EN
  logic            lock;
`endif
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [N-1:0]    ptr;
  logic            preempt;
  // Debug visibility: FSM state (0 = IDLE, 1 = GRANT) and hold counter.
  logic            fsm_state;
  logic [HC_W-1:0] hold_cnt;

`ifdef RR_ARB_LOCK_EN
  modport master (output req, lock,
                  input  gnt, gnt_valid, gnt_id, ptr, preempt, fsm_state, hold_cnt);
  modport slave  (input  req, lock,
                  output gnt, gnt_valid, gnt_id, ptr, preempt, fsm_state, hold_cnt);
`else
  modport master (output req,
                  input  gnt, gnt_valid, gnt_id, ptr, preempt, fsm_state, hold_cnt);
  modport slave  (input  req,
                  output gnt, gnt_valid, gnt_id, ptr, preempt, fsm_state, hold_cnt);
`endif
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and hold-time preemption.
// Optional macro RR_ARB_LOCK_EN adds a lock input that suppresses preemption.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = 2
) (
  input  logic clk,
  input  logic reset,
  ring_rr_arbiter_if.slave bus
);
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            valid_q, valid_d;
  logic            preempt_q, preempt_d;
  logic [HC_W-1:0] hold_q, hold_d;

  logic [N-1:0]    pick;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic            owner_req, others, at_max, lock_ok;

  // Cyclic search for the first request at or above the pointer bit.
  always_comb begin : search_blk
    int base;
    int idx;
    base     = 0;
    idx      = 0;
    pick     = '0;
    pick_id  = '0;
    pick_any = 1'b0;
    for (int b = 0; b < N; b++) if (ptr_q[b]) base = b;
    for (int i = 0; i < N; i++) begin
      idx = (base + i) % N;
      if (!pick_any && bus.req[idx]) begin
        pick_any  = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = ID_W'(idx);
      end
    end
  end

  assign owner_req = |(bus.req & gnt_q);
  assign others    = |(bus.req & ~gnt_q);
  assign at_max    = (hold_q == HC_W'(MAX_HOLD));
`ifdef RR_ARB_LOCK_EN
  assign lock_ok   = ~bus.lock;
`else
  assign lock_ok   = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          id_d    = pick_id;
          hold_d  = HC_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || (at_max && others && lock_ok)) begin
          // Release or preemption: the ring advances past the owner.
          gnt_d     = '0;
          id_d      = '0;
          hold_d    = '0;
          ptr_d     = {gnt_q[N-2:0], gnt_q[N-1]};
          preempt_d = owner_req;
          state_d   = IDLE;
        end else if (!at_max) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= N'(1);
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = id_q;
  assign bus.ptr       = ptr_q;
  assign bus.preempt   = preempt_q;
  assign bus.fsm_state = state_q;
  assign bus.hold_cnt  = hold_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter: reset, rotation, wrap, preemption,
// saturation without competitors and asynchronous reset mid-grant.
module tb_ring_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int ID_W     = 2;
  localparam int HC_W     = $clog2(MAX_HOLD + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] ptr_q[$];
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_ptr;

  ring_rr_arbiter_if #(.N(N), .ID_W(ID_W), .HC_W(HC_W)) bus ();

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req = '0;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    // Reset state, then release at 17ns
    #16;
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_valid", bus.gnt_valid, 1'b0);
    check("rst_id", bus.gnt_id, 2'd0);
    check("rst_ptr", bus.ptr, 4'b0001);
    check("rst_preempt", bus.preempt, 1'b0);
    check("rst_hold", bus.hold_cnt, 4'd0);
    check("rst_state", bus.fsm_state, 1'b0);
    #1 reset = 1'b1;

    // 1. Single requester held 5 cycles
    bus.req = 4'b0001;
    tick();
    check("single_gnt", bus.gnt, 4'b0001);
    check("single_id", bus.gnt_id, 2'd0);
    check("single_valid", bus.gnt_valid, 1'b1);
    repeat (4) tick();
    check("single_hold_gnt", bus.gnt, 4'b0001);
    check("single_hold_cnt", bus.hold_cnt, 4'd5);
    bus.req = 4'b0000;
    tick();
    check("single_rel_gnt", bus.gnt, 4'b0000);
    check("single_rel_ptr", bus.ptr, 4'b0010);
    check("single_rel_state", bus.fsm_state, 1'b0);
    tick();
    check("single_idle_ptr", bus.ptr, 4'b0010);

    // 2. All requesters, each owner drops after 2 grant cycles
    apply_reset();
    check("rr_start_ptr", bus.ptr, 4'b0001);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ptr_q = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = exp_q.pop_front();
      exp_ptr = ptr_q.pop_front();
      tick();
      check("rr_grant", bus.gnt, exp_gnt);
      check("rr_id", bus.gnt_id, k % 4);
      tick();
      check("rr_hold", bus.gnt, exp_gnt);
      bus.req = 4'b1111 & ~exp_gnt;
      tick();
      check("rr_gap_valid", bus.gnt_valid, 1'b0);
      check("rr_gap_id", bus.gnt_id, 2'd0);
      check("rr_ptr", bus.ptr, exp_ptr);
      check("rr_no_preempt", bus.preempt, 1'b0);
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    tick();

    // 3. Wrap: move ptr to bit3 via a grant to bit2, then req=0101
    bus.req = 4'b0100;
    tick();
    check("wrap_setup_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    tick();
    check("wrap_setup_ptr", bus.ptr, 4'b1000);
    bus.req = 4'b0101;
    tick();
    check("wrap_gnt", bus.gnt, 4'b0001);
    check("wrap_id", bus.gnt_id, 2'd0);
    bus.req = 4'b0000;
    tick();
    check("wrap_rel_ptr", bus.ptr, 4'b0010);

    // 4. Preemption after MAX_HOLD cycles with a competitor waiting
    apply_reset();
    bus.req = 4'b0011;
    tick();
    check("pre_first_gnt", bus.gnt, 4'b0001);
    for (int c = 0; c < 7; c++) begin
      tick();
      check("pre_held_gnt", bus.gnt, 4'b0001);
      check("pre_held_preempt", bus.preempt, 1'b0);
    end
    check("pre_hold_max", bus.hold_cnt, 4'd8);
    tick();
    check("pre_gap_gnt", bus.gnt, 4'b0000);
    check("pre_pulse", bus.preempt, 1'b1);
    check("pre_ptr", bus.ptr, 4'b0010);
    tick();
    check("pre_next_gnt", bus.gnt, 4'b0010);
    check("pre_next_id", bus.gnt_id, 2'd1);
    check("pre_pulse_end", bus.preempt, 1'b0);
    bus.req = 4'b0000;
    tick();
    check("pre_rel_ptr", bus.ptr, 4'b0100);

    // 5. No competitor: grant held, counter saturates
    bus.req = 4'b0001;
    tick();
    check("solo_gnt", bus.gnt, 4'b0001);
    for (int c = 0; c < 19; c++) begin
      tick();
      check("solo_no_preempt", bus.preempt, 1'b0);
    end
    check("solo_held_gnt", bus.gnt, 4'b0001);
    check("solo_hold_sat", bus.hold_cnt, 4'd8);
    bus.req = 4'b0000;
    tick();
    check("solo_rel_ptr", bus.ptr, 4'b0010);

    // 6. Asynchronous reset mid-grant
    bus.req = 4'b0100;
    tick();
    check("arst_pre_gnt", bus.gnt, 4'b0100);
    #2 reset = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 4'b0000);
    check("arst_valid", bus.gnt_valid, 1'b0);
    check("arst_id", bus.gnt_id, 2'd0);
    check("arst_ptr", bus.ptr, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("arst_regrant", bus.gnt, 4'b0100);
    check("arst_regrant_id", bus.gnt_id, 2'd2);
    bus.req = 4'b0000;
    tick();
    check("arst_rel_ptr", bus.ptr, 4'b1000);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource between N requesters. It uses a one-hot rotating priority ring, so the priority pointer shifts and wraps exactly like the team's ring counter. Grants are registered and held while the owner keeps its request asserted. An owner is preempted after MAX_HOLD cycles if another requester is waiting. Sits between the requester blocks and the shared datapath's enable/select inputs.

Parameters:
N, 4, number of requesters (>=2)
MAX_HOLD, 8, max consecutive grant cycles before preemption is allowed (>=1)
ID_W, 2, width of gnt_id (>= clog2(N))

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
req  input  N  request per requester, level; held high while service wanted
gnt  output  N  registered one-hot grant, all-zero when idle
gnt_valid  output  1  OR of gnt, registered
gnt_id  output  ID_W  binary index of gnt bit; 0 when gnt_valid=0
ptr  output  N  one-hot priority pointer; bit set = highest-priority requester
preempt  output  1  one-cycle pulse on the edge a grant is forcibly removed

Behaviour:
- Reset (reset=0, async): gnt=0, gnt_valid=0, gnt_id=0, ptr=1 (bit0), preempt=0, hold_cnt=0, state IDLE.
- hold_cnt: clog2(MAX_HOLD+1) bits; saturates at MAX_HOLD, never wraps.
- State IDLE:
  - If req!=0 at an edge, grant the first set req bit searching cyclically from ptr's bit upward (N-1 wraps to 0).
  - Set gnt/gnt_id/gnt_valid; hold_cnt=1; go to GRANT.
  - Latency is 1 cycle: req sampled at edge k, gnt visible after edge k.
  - If req==0: remain IDLE, outputs 0.
- State GRANT, evaluated each edge with h = owner index:
  - Normal release, when req[h]=0: gnt=0, gnt_valid=0, gnt_id=0; ptr = one-hot(h) rotated left by 1 with wrap (bit N-1 -> bit0); go to IDLE.
  - Preempt, when req[h]=1, hold_cnt==MAX_HOLD, and (req & ~gnt)!=0: same as normal release, plus preempt=1 for exactly one cycle.
  - Otherwise: keep the grant; hold_cnt increments (saturating).
  - With no competing request, the owner holds the grant indefinitely.
- Turnaround: every grant release is followed by at least one cycle with gnt=0. Back-to-back grants are never adjacent.
- Simultaneous events:
  - A release and a new request on the same edge: the new request is considered only at the following IDLE edge.
  - Requests arriving during GRANT are ignored for selection until IDLE.
- ptr changes only on a release or preempt edge, never in IDLE.
- gnt is always one-hot or zero. gnt_id always matches gnt.
- A reset assertion mid-grant drops gnt immediately (async) and restores ptr=1.

Optional Feature:
Macro RR_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While gnt_valid=1 and lock=1, preemption is suppressed. hold_cnt still saturates, and normal release via req[h]=0 still applies. If lock deasserts while hold_cnt==MAX_HOLD and others are waiting, preempt fires on the next edge.
- Not defined: no lock port; preemption as described above.

Test Plan:
1. Single requester: release reset at 17ns, req=0001 for 5 cycles then 0 -> gnt=0001 one cycle after req; gnt_id=0; after release gnt=0 and ptr=0010.
2. All requesters: req=1111 held, each owner drops its req after 2 grant cycles -> grant order 0,1,2,3,0; one idle cycle between grants; ptr sequence 0010,0100,1000,0001.
3. Wrap priority: force ptr=1000 via prior grant to bit2, then req=0101 -> gnt=0001 (bit3 absent, search wraps to bit0).
4. Preemption: req=0011 held, MAX_HOLD=8 -> bit0 granted for exactly 8 cycles; preempt=1 for one cycle; one gap cycle; then gnt=0010.
5. No competitor: req=0001 held for 20 cycles -> gnt stays 0001; preempt never fires; hold_cnt saturates at 8.
6. Reset mid-grant: gnt=0100, drive reset=0 between clock edges -> gnt=0, gnt_valid=0, ptr=0001 immediately. After release with req=0100 -> gnt=0100 one cycle later.
